// File: rtl/apb_dual_master_arb.sv
// APB master for a two-slave subsystem: round-robin arbitration between two local
// requesters, IDLE/SETUP/ACCESS sequencing, address decode and wait-state timeout.
module apb_dual_master_arb #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W:0]   addr0,
    input  logic [ADDR_W:0]   addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              PSEL1,
    output logic              PSEL2,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA1,
    input  logic [DATA_W-1:0] PRDATA2,
    input  logic              PREADY1,
    input  logic              PREADY2
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    // Requester-side inputs gathered into arrays so the grant mux is indexed by id.
    logic              req_vec   [2];
    logic              wr_vec    [2];
    logic [ADDR_W:0]   addr_vec  [2];
    logic [DATA_W-1:0] wdata_vec [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            if (gi == 0) begin : g_r0
                assign req_vec[gi]   = req0;
                assign wr_vec[gi]    = wr0;
                assign addr_vec[gi]  = addr0;
                assign wdata_vec[gi] = wdata0;
            end else begin : g_r1
                assign req_vec[gi]   = req1;
                assign wr_vec[gi]    = wr1;
                assign addr_vec[gi]  = addr1;
                assign wdata_vec[gi] = wdata1;
            end
        end
    endgenerate

    state_t            state_reg,   state_next;
    logic              owner_reg,   owner_next;
    logic              prio_reg,    prio_next;
    logic              wr_reg,      wr_next;
    logic [ADDR_W:0]   addr_reg,    addr_next;
    logic [DATA_W-1:0] wdata_reg,   wdata_next;
    logic [7:0]        wait_reg,    wait_next;
    logic              done0_reg,   done0_next;
    logic              done1_reg,   done1_next;
    logic              err_reg,     err_next;
    logic [DATA_W-1:0] rdata_reg,   rdata_next;
    logic              psel1_reg,   psel1_next;
    logic              psel2_reg,   psel2_next;
    logic              penable_reg, penable_next;

    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;
    logic              arb_en;
    logic              mask0, mask1;
    logic              cand0, cand1;
    logic              grant_id;

    assign sel_ready = addr_reg[ADDR_W] ? PREADY2 : PREADY1;
    assign sel_rdata = addr_reg[ADDR_W] ? PRDATA2 : PRDATA1;

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        prio_next    = prio_reg;
        wr_next      = wr_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        wait_next    = wait_reg;
        done0_next   = 1'b0;
        done1_next   = 1'b0;
        err_next     = 1'b0;
        rdata_next   = rdata_reg;
        psel1_next   = psel1_reg;
        psel2_next   = psel2_reg;
        penable_next = penable_reg;
        arb_en       = 1'b0;
        mask0        = 1'b0;
        mask1        = 1'b0;
        cand0        = 1'b0;
        cand1        = 1'b0;
        grant_id     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                arb_en = 1'b1;
            end
            ST_SETUP: begin
                state_next   = ST_ACCESS;
                penable_next = 1'b1;
                wait_next    = 8'd0;
            end
            ST_ACCESS: begin
                // A ready on the last allowed wait cycle wins over the timeout.
                if (sel_ready || (wait_reg == WAIT_LAST)) begin
                    if (sel_ready) begin
                        rdata_next = wr_reg ? rdata_reg : sel_rdata;
                    end else begin
                        err_next   = 1'b1;
                        rdata_next = '0;
                    end
                    done0_next   = ~owner_reg;
                    done1_next   = owner_reg;
                    psel1_next   = 1'b0;
                    psel2_next   = 1'b0;
                    penable_next = 1'b0;
                    state_next   = ST_IDLE;
                    arb_en       = 1'b1;
                    // The finishing requester still holds req this edge; ignore it.
                    mask0        = ~owner_reg;
                    mask1        = owner_reg;
                end else begin
                    wait_next = wait_reg + 8'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (arb_en) begin
            cand0 = req_vec[0] & ~mask0;
            cand1 = req_vec[1] & ~mask1;
            if (cand0 || cand1) begin
                grant_id     = (cand0 && cand1) ? prio_reg : cand1;
                owner_next   = grant_id;
                prio_next    = ~grant_id;
                wr_next      = wr_vec[grant_id];
                addr_next    = addr_vec[grant_id];
                wdata_next   = wdata_vec[grant_id];
                psel1_next   = ~addr_vec[grant_id][ADDR_W];
                psel2_next   = addr_vec[grant_id][ADDR_W];
                penable_next = 1'b0;
                state_next   = ST_SETUP;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg   <= ST_IDLE;
            owner_reg   <= 1'b0;
            prio_reg    <= 1'b0;
            wr_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wait_reg    <= 8'd0;
            done0_reg   <= 1'b0;
            done1_reg   <= 1'b0;
            err_reg     <= 1'b0;
            rdata_reg   <= '0;
            psel1_reg   <= 1'b0;
            psel2_reg   <= 1'b0;
            penable_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            prio_reg    <= prio_next;
            wr_reg      <= wr_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            wait_reg    <= wait_next;
            done0_reg   <= done0_next;
            done1_reg   <= done1_next;
            err_reg     <= err_next;
            rdata_reg   <= rdata_next;
            psel1_reg   <= psel1_next;
            psel2_reg   <= psel2_next;
            penable_reg <= penable_next;
        end
    end

    assign done0   = done0_reg;
    assign done1   = done1_reg;
    assign err     = err_reg;
    assign rdata   = rdata_reg;
    assign PSEL1   = psel1_reg;
    assign PSEL2   = psel2_reg;
    assign PENABLE = penable_reg;
    assign PWRITE  = wr_reg;
    assign PADDR   = addr_reg[ADDR_W-1:0];
    assign PWDATA  = wdata_reg;

endmodule

// File: tb/tb_apb_dual_master_arb.sv
// Directed bench for apb_dual_master_arb: write, waited read, contention,
// timeout / last-cycle ready, and asynchronous reset mid-transfer.
module tb_apb_dual_master_arb;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic          wr0 = 1'b0, wr1 = 1'b0;
    logic [AW:0]   addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          done0, done1, err;
    logic [DW-1:0] rdata;
    logic          PSEL1, PSEL2, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA1 = '0, PRDATA2 = '0;
    logic          PREADY1 = 1'b0, PREADY2 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Bus status vector: {PSEL1, PSEL2, PENABLE, done0, done1, err}
    logic [5:0] bus;
    assign bus = {PSEL1, PSEL2, PENABLE, done0, done1, err};

    apb_dual_master_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .err(err), .rdata(rdata),
        .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY1(PREADY1), .PREADY2(PREADY2)
    );

    always #5 PCLK = ~PCLK;

    task automatic apply_reset;
        PRESETn = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        PREADY1 = 1'b0; PREADY2 = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
    endtask

    task automatic test_reset;
        PRESETn = 1'b0;
        #1;
        n_checks++;
        if ({bus, PWRITE, PADDR, PWDATA, rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got bus=%b PWRITE=%b PADDR=%h PWDATA=%h rdata=%h want all 0",
                     bus, PWRITE, PADDR, PWDATA, rdata);
        end
        apply_reset();
        $display("reset: outputs checked");
    endtask

    task automatic test_write;
        @(negedge PCLK);
        req0 = 1'b1; wr0 = 1'b1; addr0 = 9'h005; wdata0 = 8'hA5; PREADY1 = 1'b1; PREADY2 = 1'b0;
        n_checks++;
        if (bus !== 6'b000000) begin n_fail++; $display("FAIL write_idle: got %b want 000000", bus); end
        @(negedge PCLK);
        n_checks++;
        if ({bus, PWRITE, PADDR, PWDATA} !== {6'b100000, 1'b1, 8'h05, 8'hA5}) begin
            n_fail++;
            $display("FAIL write_setup: got bus=%b PWRITE=%b PADDR=%h PWDATA=%h want 100000 1 05 a5",
                     bus, PWRITE, PADDR, PWDATA);
        end
        @(negedge PCLK);
        n_checks++;
        if ({bus, PWRITE, PADDR, PWDATA} !== {6'b101000, 1'b1, 8'h05, 8'hA5}) begin
            n_fail++;
            $display("FAIL write_access: got bus=%b PWRITE=%b PADDR=%h PWDATA=%h want 101000 1 05 a5",
                     bus, PWRITE, PADDR, PWDATA);
        end
        @(negedge PCLK);
        n_checks++;
        if (bus !== 6'b000100) begin n_fail++; $display("FAIL write_done: got %b want 000100", bus); end
        req0 = 1'b0;
        @(negedge PCLK);
        n_checks++;
        if (bus !== 6'b000000) begin n_fail++; $display("FAIL write_after: got %b want 000000", bus); end
        $display("write slave1 addr=05 data=a5 complete");
    endtask

    task automatic test_read;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 9'h10A; PRDATA2 = 8'h3C; PRDATA1 = 8'hFF;
        PREADY2 = 1'b0; PREADY1 = 1'b1;
        @(negedge PCLK);
        n_checks++;
        if ({bus, PWRITE, PADDR} !== {6'b010000, 1'b0, 8'h0A}) begin
            n_fail++;
            $display("FAIL read_setup: got bus=%b PWRITE=%b PADDR=%h want 010000 0 0a", bus, PWRITE, PADDR);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            n_checks++;
            if ({bus, PADDR} !== {6'b011000, 8'h0A}) begin
                n_fail++;
                $display("FAIL read_access%0d: got bus=%b PADDR=%h want 011000 0a", i, bus, PADDR);
            end
            if (i == 3) PREADY2 = 1'b1;
        end
        @(negedge PCLK);
        n_checks++;
        if ({bus, rdata} !== {6'b000010, 8'h3C}) begin
            n_fail++;
            $display("FAIL read_done: got bus=%b rdata=%h want 000010 3c", bus, rdata);
        end
        req1 = 1'b0; PREADY2 = 1'b0; PREADY1 = 1'b0;
        @(negedge PCLK);
        n_checks++;
        if (bus !== 6'b000000) begin n_fail++; $display("FAIL read_after: got %b want 000000", bus); end
        $display("read slave2 addr=0a data=%h complete", rdata);
    endtask

    task automatic test_timeout;
        for (int run = 0; run < 2; run++) begin
            req0 = 1'b1; wr0 = 1'b0; addr0 = 9'h033; PRDATA1 = 8'h77; PREADY1 = 1'b0; PREADY2 = 1'b1;
            @(negedge PCLK);
            n_checks++;
            if (bus !== 6'b100000) begin n_fail++; $display("FAIL timeout_setup%0d: got %b want 100000", run, bus); end
            for (int i = 0; i < 16; i++) begin
                @(negedge PCLK);
                n_checks++;
                if (bus !== 6'b101000) begin
                    n_fail++;
                    $display("FAIL timeout_access%0d_%0d: got %b want 101000", run, i, bus);
                end
                if (run == 1 && i == 15) PREADY1 = 1'b1;
            end
            @(negedge PCLK);
            n_checks++;
            if (run == 0) begin
                if ({bus, rdata} !== {6'b000101, 8'h00}) begin
                    n_fail++;
                    $display("FAIL timeout_abort: got bus=%b rdata=%h want 000101 00", bus, rdata);
                end
            end else begin
                if ({bus, rdata} !== {6'b000100, 8'h77}) begin
                    n_fail++;
                    $display("FAIL timeout_lastready: got bus=%b rdata=%h want 000100 77", bus, rdata);
                end
            end
            req0 = 1'b0; PREADY1 = 1'b0; PREADY2 = 1'b0;
            @(negedge PCLK);
            n_checks++;
            if (bus !== 6'b000000) begin n_fail++; $display("FAIL timeout_after%0d: got %b want 000000", run, bus); end
            $display("timeout run %0d: err=%0d rdata=%h", run, (run == 0), rdata);
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] exp;
        int t, own, prev;
        apply_reset();
        req0 = 1'b1; wr0 = 1'b1; addr0 = 9'h001;
        req1 = 1'b1; wr1 = 1'b1; addr1 = 9'h102;
        PREADY1 = 1'b1; PREADY2 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge PCLK);
            t    = (k - 1) / 2;
            own  = t % 2;
            prev = (t + 1) % 2;
            if ((k - 1) % 2 == 0)
                exp = {own == 0, own == 1, 1'b0, k >= 3 && prev == 0, k >= 3 && prev == 1, 1'b0};
            else
                exp = {own == 0, own == 1, 1'b1, 3'b000};
            n_checks++;
            if (bus !== exp) begin
                n_fail++;
                $display("FAIL contention_cycle%0d: got %b want %b", k, bus, exp);
            end
            if ((k - 1) % 2 == 0) $display("contention: transfer %0d granted to requester %0d", t, own);
        end
        apply_reset();
    endtask

    task automatic test_reset_mid;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 9'h004; PREADY1 = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        n_checks++;
        if (bus !== 6'b101000) begin n_fail++; $display("FAIL rstmid_access: got %b want 101000", bus); end
        #2 PRESETn = 1'b0;
        #1;
        n_checks++;
        if ({bus, PADDR} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: got bus=%b PADDR=%h want 0", bus, PADDR);
        end
        req1 = 1'b1; wr1 = 1'b0; addr1 = 9'h1FF;
        @(negedge PCLK);
        n_checks++;
        if (bus !== 6'b000000) begin n_fail++; $display("FAIL rstmid_nodone: got %b want 000000", bus); end
        PRESETn = 1'b1;
        @(negedge PCLK);
        n_checks++;
        if ({bus, PADDR} !== {6'b100000, 8'h04}) begin
            n_fail++;
            $display("FAIL rstmid_regrant: got bus=%b PADDR=%h want 100000 04", bus, PADDR);
        end
        $display("reset mid-access: requester 0 regranted");
        apply_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_dual_master_arb.md
Name: apb_dual_master_arb

Overview:
- APB master controller for the two-slave APB subsystem.
- Accepts transfer requests from two local requesters and arbitrates between them round-robin.
- Sequences each granted request through the APB IDLE/SETUP/ACCESS protocol, decodes it to slave 1 or slave 2, and returns read data or a timeout error to the requester.

Parameters:
- ADDR_W, 8: APB address width (PADDR); requester address is ADDR_W+1 bits, MSB selects the slave.
- DATA_W, 8: APB data width.
- TIMEOUT, 16: maximum ACCESS cycles with PREADY low before abort; legal range 1..255.

Ports:
- PCLK  in  1  system clock, all state on rising edge
- PRESETn  in  1  asynchronous active-low reset
- req0, req1  in  1  transfer request; held high until matching done pulse
- wr0, wr1  in  1  1=write, 0=read; valid while req high
- addr0, addr1  in  ADDR_W+1  bit ADDR_W: 0=slave1, 1=slave2; low ADDR_W bits go to PADDR
- wdata0, wdata1  in  DATA_W  write data
- done0, done1  out  1  one-cycle completion pulse to the owning requester
- err  out  1  valid with done: 1=timeout abort
- rdata  out  DATA_W  read data, valid with done of a read
- PSEL1, PSEL2  out  1  slave selects, one-hot or zero
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA1, PRDATA2  in  DATA_W  slave read data
- PREADY1, PREADY2  in  1  slave ready

Behaviour:
- Reset (async, PRESETn low): FSM=IDLE; all outputs 0; round-robin pointer=0, so requester 0 has priority next; wait counter=0. Effective immediately, including mid-transfer. No done is issued for an aborted transfer.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if any req is high at a clock edge, grant and go to SETUP.
- SETUP: PSELx=1, PENABLE=0. Always go to ACCESS after one cycle.
- ACCESS: PSELx=1, PENABLE=1. The transfer completes at the edge where the selected PREADY is 1.
- Grant latching: at grant, latch requester id, wr, addr and wdata. PADDR, PWRITE, PWDATA and PSELx are registered from the latch and stay stable from SETUP through the end of ACCESS.
- Arbitration: if only one req is high, grant it. If both are high, grant the requester not granted last time. The pointer updates at each grant; after reset, requester 0 wins a tie.
- Decode: latched addr MSB=0 drives PSEL1 and uses PRDATA1/PREADY1; MSB=1 drives PSEL2 and uses PRDATA2/PREADY2. The unselected PREADY is ignored.
- Completion edge actions:
  - done_owner=1 for the next cycle, err=0.
  - For a read, rdata = selected PRDATA sampled at that edge; for a write, rdata is unchanged.
  - PSEL and PENABLE deassert.
- Back-to-back: at the completion edge, the arbiter evaluates req with the completing requester's req masked, since its req is still high.
  - If the other requester is pending, go directly to SETUP (no IDLE cycle); otherwise go to IDLE.
  - The completing requester may deassert or re-raise req the cycle after done. A req seen during the done cycle is a new request.
- Timeout:
  - The wait counter is cleared on entering ACCESS and increments each ACCESS cycle with the selected PREADY=0.
  - When the counter equals TIMEOUT-1 and PREADY is still 0, abort: done_owner=1 and err=1 next cycle, rdata=0, PSEL/PENABLE deassert, then next-state follows the back-to-back rule.
  - A PREADY=1 on the same edge takes precedence: the transfer completes normally with no error.
- Outputs err and done are 0 except in the done cycle. done0 and done1 are never high together.
- Nominal latency with zero wait states: req high at edge N → SETUP cycle N+1 → ACCESS cycle N+2 → done high in cycle N+3.

Test Plan:
- Write, slave 1: req0, wr0=1, addr0=0x005, wdata0=0xA5, PREADY1=1 in ACCESS → PSEL1 high 2 cycles, PENABLE high in cycle 2 only, PADDR=0x05, PWDATA=0xA5, done0 3 cycles after req, err=0, PSEL2 never high.
- Read, slave 2: req1, wr1=0, addr1=0x10A, PRDATA2=0x3C, PREADY2 low 3 ACCESS cycles then high → PSEL2 only, PADDR=0x0A, 4 ACCESS cycles, done1 with rdata=0x3C, err=0.
- Contention: req0 and req1 both high from reset, zero wait states → grants alternate 0,1,0,1, with SETUP immediately after each completion (no IDLE cycle) and exactly one done per transfer.
- Timeout: PREADY1 held 0, TIMEOUT=16 → exactly 16 ACCESS cycles, then done0=1, err=1, rdata=0x00, bus idle next cycle. Repeat with PREADY1 rising on the 16th ACCESS cycle → normal completion, err=0.
- Reset mid-ACCESS: assert PRESETn low during ACCESS → all outputs 0 asynchronously with no done. After release, with req0 and req1 both high, requester 0 is granted first.
